alu_issue_ctrl: RTL and testbench

Initiator/collector for the registered ALU adder. Accepts operand pairs over a valid/ready command interface and drives them onto the ALU A/B inputs. Waits the ALU's fixed pipeline latency, then captures ALU_out and derives the overflow, carry and zero flags, which the ALU does not drive. Returns the result over a valid/ready result interface; sits between the datapath sequencer and the ALU.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_flag_gen.sv | 24 ++
 rtl/alu_issue_ctrl.sv | 124 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU issue/collect controller family.
package alu_pkg;

    // Default datapath width; must match the ALU data width.
    localparam int ALU_WIDTH = 18;

    // Default ALU register stages between A/B and ALU_out.
    localparam int ALU_LAT = 1;

    // Wait counter width; covers latencies 0..7.
    localparam int CNT_W = 3;

    // Controller states: idle (accepting), waiting on the ALU pipeline,
    // holding a result until the consumer takes it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational flag derivation for an addition: signed overflow,
// unsigned carry out of the MSB, and zero detect.
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] sum,
    output logic             ovf,
    output logic             carry,
    output logic             isZero
);

    // Signed overflow: operands agree in sign but the sum does not.
    // Carry: a wrapped modulo-2^WIDTH sum is always smaller than an operand.
    always_comb begin
        ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        carry  = (sum < a);
        isZero = (sum == '0);
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues operand pairs to a registered ALU adder, waits out its pipeline
// latency, then captures the sum together with derived flags.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. The command side (cmd_valid/cmd_ready) must hold its
// operands stable until cmd_ready; the result side (res_valid/res_ready)
// keeps res_data and flags stable while res_valid is high and drops
// res_valid after the edge where res_ready is seen.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int LAT   = ALU_LAT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_ovf,
    output logic             res_carry,
    output logic             res_isZero
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;

    logic accept;
    logic capture;
    logic release_res;

    logic flag_ovf;
    logic flag_carry;
    logic flag_zero;

    // Handshake and phase qualifiers derived from the current state.
    always_comb begin
        cmd_ready   = (state == IDLE) && !rst;
        accept      = cmd_valid && cmd_ready;
        capture     = (state == WAIT) && (cnt == '0);
        release_res = (state == HOLD) && res_ready;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)      state_nxt = WAIT;
            WAIT:    if (capture)     state_nxt = HOLD;
            HOLD:    if (release_res) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand registers: loaded on accept, held until the next accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a <= '0;
            alu_b <= '0;
        end else if (accept) begin
            alu_a <= cmd_a;
            alu_b <= cmd_b;
        end
    end

    // Latency counter: loaded with LAT on accept, counts down in WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= CNT_W'(LAT);
        end else if ((state == WAIT) && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    alu_flag_gen #(
        .WIDTH (WIDTH)
    ) u_flag_gen (
        .a      (alu_a),
        .b      (alu_b),
        .sum    (alu_out),
        .ovf    (flag_ovf),
        .carry  (flag_carry),
        .isZero (flag_zero)
    );

    // Result capture at the end of the wait; res_valid clears on handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_data   <= '0;
            res_ovf    <= 1'b0;
            res_carry  <= 1'b0;
            res_isZero <= 1'b0;
            res_valid  <= 1'b0;
        end else if (capture) begin
            res_data   <= alu_out;
            res_ovf    <= flag_ovf;
            res_carry  <= flag_carry;
            res_isZero <= flag_zero;
            res_valid  <= 1'b1;
        end else if (release_res) begin
            res_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: three instances (LAT = 1, 0, 3), each with its
// own ALU pipeline model, driver, random consumer and scoreboard monitor.
module tb_alu_issue_ctrl;

    localparam int W = 18;

    logic clk = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   done [0:2];

    // Clock.
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    // Packed as {sum, ovf, carry, zero}.
    function automatic logic [W+2:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b);
        longint m  = longint'(1) << W;
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint u  = ua + ub;
        longint sm = u % m;
        longint sa = (ua >= m / 2) ? ua - m : ua;
        longint sb = (ub >= m / 2) ? ub - m : ub;
        longint ss = sa + sb;
        logic   ovf   = (ss > m / 2 - 1) || (ss < -(m / 2));
        logic   carry = (u >= m);
        logic   zero  = (sm == 0);
        return {W'(sm), ovf, carry, zero};
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_inst
        localparam int L = (gi == 0) ? 1 : ((gi == 1) ? 0 : 3);

        logic         rst;
        logic         cmd_valid;
        logic         cmd_ready;
        logic [W-1:0] cmd_a;
        logic [W-1:0] cmd_b;
        logic [W-1:0] alu_a;
        logic [W-1:0] alu_b;
        logic [W-1:0] alu_out;
        logic         res_valid;
        logic         res_ready;
        logic [W-1:0] res_data;
        logic         res_ovf;
        logic         res_carry;
        logic         res_is_zero;

        bit           stall = 1'b0;
        int           cyc = 0;
        logic [W+2:0] exp_q[$];
        int           exp_cyc_q[$];
        logic [W-1:0] pipe [0:7];

        alu_issue_ctrl #(
            .WIDTH (W),
            .LAT   (L)
        ) dut (
            .clk        (clk),
            .rst        (rst),
            .cmd_valid  (cmd_valid),
            .cmd_ready  (cmd_ready),
            .cmd_a      (cmd_a),
            .cmd_b      (cmd_b),
            .alu_a      (alu_a),
            .alu_b      (alu_b),
            .alu_out    (alu_out),
            .res_valid  (res_valid),
            .res_ready  (res_ready),
            .res_data   (res_data),
            .res_ovf    (res_ovf),
            .res_carry  (res_carry),
            .res_isZero (res_is_zero)
        );

        // ALU model: adder followed by L register stages.
        always @(posedge clk) begin
            pipe[0] <= alu_a + alu_b;
            for (int k = 1; k < 8; k++) pipe[k] <= pipe[k-1];
            cyc <= cyc + 1;
        end
        assign alu_out = (L == 0) ? alu_a + alu_b : pipe[(L == 0) ? 0 : L - 1];

        // Consumer: random res_ready changed just after each rising edge.
        initial begin
            res_ready = 1'b0;
            forever begin
                @(posedge clk);
                #1;
                res_ready = stall ? 1'b0 : ($urandom_range(0, 2) != 0);
            end
        end

        // Monitor: pops an expectation on each new result, checks latency,
        // value stability while held, and the return to idle after handshake.
        initial begin
            logic [W+2:0] cur = '0;
            int           cur_cyc = 0;
            bit           have = 1'b0;
            bit           prev_valid = 1'b0;
            bit           prev_hs = 1'b0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    prev_valid = 1'b0;
                    prev_hs    = 1'b0;
                    have       = 1'b0;
                end else begin
                    if (prev_hs) begin
                        check($sformatf("L%0d valid_drop", L), res_valid, 0);
                        check($sformatf("L%0d idle_after_hs", L), cmd_ready, 1);
                    end
                    if (res_valid) begin
                        if (!prev_valid) begin
                            if (exp_q.size() == 0) begin
                                checks++;
                                errors++;
                                have = 1'b0;
                                $display("FAIL L%0d unexpected_result: got data %0h expected no result", L, res_data);
                            end else begin
                                cur     = exp_q.pop_front();
                                cur_cyc = exp_cyc_q.pop_front();
                                have    = 1'b1;
                                check($sformatf("L%0d latency", L), cyc, cur_cyc);
                            end
                        end
                        if (have) begin
                            check($sformatf("L%0d res_data", L), res_data, cur[W+2:3]);
                            check($sformatf("L%0d res_ovf", L), res_ovf, cur[2]);
                            check($sformatf("L%0d res_carry", L), res_carry, cur[1]);
                            check($sformatf("L%0d res_isZero", L), res_is_zero, cur[0]);
                        end
                        check($sformatf("L%0d busy_while_hold", L), cmd_ready, 0);
                    end
                    prev_valid = res_valid;
                    prev_hs    = res_valid && res_ready;
                end
            end
        end

        // Issue one command; returns just after the accepting edge.
        task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
            int n = 0;
            @(negedge clk);
            cmd_a     = a;
            cmd_b     = b;
            cmd_valid = 1'b1;
            while (!cmd_ready && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (!cmd_ready) begin
                checks++;
                errors++;
                $display("FAIL L%0d cmd_timeout: got cmd_ready 0 expected 1 within 100 cycles", L);
                cmd_valid = 1'b0;
            end else begin
                exp_q.push_back(ref_model(a, b));
                exp_cyc_q.push_back(cyc + 2 + L);
                @(posedge clk);
                #1;
                cmd_valid = 1'b0;
                cmd_a     = W'($urandom);
                cmd_b     = W'($urandom);
            end
        endtask

        // Wait until all expected results were consumed and the block is idle.
        task automatic wait_idle();
            int n = 0;
            @(negedge clk);
            while ((exp_q.size() != 0 || !cmd_ready) && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (exp_q.size() != 0 || !cmd_ready) begin
                checks++;
                errors++;
                $display("FAIL L%0d drain_timeout: got %0d pending expected 0", L, exp_q.size());
            end
        endtask

        task automatic check_reset_outputs(input string tag);
            check($sformatf("L%0d %s cmd_ready", L, tag), cmd_ready, 0);
            check($sformatf("L%0d %s res_valid", L, tag), res_valid, 0);
            check($sformatf("L%0d %s alu_a", L, tag), alu_a, 0);
            check($sformatf("L%0d %s alu_b", L, tag), alu_b, 0);
            check($sformatf("L%0d %s res_data", L, tag), res_data, 0);
            check($sformatf("L%0d %s flags", L, tag), {res_ovf, res_carry, res_is_zero}, 0);
        endtask

        // Driver.
        initial begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            int           n;
            rst       = 1'b1;
            cmd_valid = 1'b0;
            cmd_a     = '0;
            cmd_b     = '0;
            repeat (3) @(negedge clk);
            check_reset_outputs("reset");
            rst = 1'b0;
            @(negedge clk);
            check($sformatf("L%0d ready_after_reset", L), cmd_ready, 1);
            check($sformatf("L%0d valid_after_reset", L), res_valid, 0);

            // Directed arithmetic corners.
            send(18'd5, 18'd7);
            send(18'h1FFFF, 18'h00001);
            send(18'h20000, 18'h20000);
            send(18'h3FFFF, 18'h00001);
            wait_idle();

            // Stalled consumer: result held, commands ignored.
            stall = 1'b1;
            send(W'($urandom), W'($urandom));
            n = 0;
            while (!res_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("L%0d stall_result_seen", L), res_valid, 1);
            repeat (5) begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_a     = W'($urandom);
                cmd_b     = W'($urandom);
                @(negedge clk);
                check($sformatf("L%0d stall_ready", L), cmd_ready, 0);
                check($sformatf("L%0d stall_valid", L), res_valid, 1);
            end
            cmd_valid = 1'b0;
            stall     = 1'b0;
            wait_idle();

            // Reset during WAIT discards the operation.
            send(W'($urandom), W'($urandom));
            rst = 1'b1;
            exp_q.delete();
            exp_cyc_q.delete();
            #1;
            check_reset_outputs("mid_wait_reset");
            repeat (2) @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            check($sformatf("L%0d ready_after_mid_reset", L), cmd_ready, 1);
            send(18'd1, 18'd2);
            wait_idle();

            // Randomized traffic with occasional corner operands.
            for (int i = 0; i < 25; i++) begin
                a = ($urandom_range(0, 3) == 0) ? W'(18'h3FFFF - $urandom_range(0, 1) * 18'h20000) : W'($urandom);
                b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 2)) : W'($urandom);
                send(a, b);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            wait_idle();
            done[gi] = 1'b1;
        end
    end

    // Summary once every instance has drained, with a cycle budget.
    initial begin
        int n = 0;
        while (!(done[0] && done[1] && done[2]) && n < 40000) begin
            @(negedge clk);
            n++;
        end
        if (!(done[0] && done[1] && done[2])) begin
            checks++;
            errors++;
            $display("FAIL global_timeout: got incomplete run expected all drivers done");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
